// File: rtl/jogo_pkg.sv
// Shared state encodings and defaults for the round-based memory game control unit.
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  localparam logic [3:0] DB_INVALIDO = 4'hF;
  localparam int TIMEOUT_CYCLES_PADRAO = 5000;

endpackage

// File: rtl/contador_timeout.sv
// Per-play response timer: counts while conta is high, clears whenever conta drops.
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TW = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic conta,
  output logic fim
);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || !conta) count <= '0;
    else                 count <= count + TW'(1);
  end

  assign fim = (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/jogo_rodadas_unidade_controle.sv
// Moore control unit for the round-based memory game.
// Define JOGO_TIMEOUT_EN to build the per-play response timeout.
module jogo_rodadas_unidade_controle
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_PADRAO,
  parameter int TW = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado, proximoEstado;
  logic fimTimeout;

  if (TIMEOUT_CYCLES < 2 || (longint'(1) << TW) < longint'(TIMEOUT_CYCLES)) begin : g_param_invalido
    $error("contador de timeout: TIMEOUT_CYCLES deve ser >= 2 e caber em TW bits");
  end

`ifdef JOGO_TIMEOUT_EN
  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TW(TW)
  ) u_contador_timeout (
    .clock(clock),
    .reset(reset),
    .conta(estado == ESPERA_JOGADA),
    .fim(fimTimeout)
  );
`else
  assign fimTimeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximoEstado;
  end

  always_comb begin
    proximoEstado = INICIAL;
    case (estado)
      INICIAL:        proximoEstado = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     proximoEstado = INICIO_RODADA;
      INICIO_RODADA:  proximoEstado = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (jogada)          proximoEstado = REGISTRA;
        else if (fimTimeout) proximoEstado = FIM_TIMEOUT;
        else                 proximoEstado = ESPERA_JOGADA;
      end
      REGISTRA:       proximoEstado = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     proximoEstado = FIM_ERROU;
        else if (!fimE) proximoEstado = PROXIMA_JOGADA;
        else if (!fimL) proximoEstado = PROXIMA_RODADA;
        else            proximoEstado = FIM_ACERTOU;
      end
      PROXIMA_JOGADA: proximoEstado = ESPERA_JOGADA;
      PROXIMA_RODADA: proximoEstado = INICIO_RODADA;
      FIM_ACERTOU:    proximoEstado = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:      proximoEstado = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef JOGO_TIMEOUT_EN
      FIM_TIMEOUT:    proximoEstado = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
      default:        proximoEstado = INICIAL;
    endcase
  end

  // Without the timeout feature FIM_TIMEOUT behaves like any unused code.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraL     = 1'b0;
    contaL    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    db_estado = DB_INVALIDO;
    case (estado)
      INICIAL, PREPARACAO: begin
        zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1;
        db_estado = estado;
      end
      INICIO_RODADA:  begin zeraE = 1'b1; db_estado = estado; end
      ESPERA_JOGADA:  db_estado = estado;
      REGISTRA:       begin registraR = 1'b1; db_estado = estado; end
      COMPARACAO:     db_estado = estado;
      PROXIMA_JOGADA: begin contaE = 1'b1; db_estado = estado; end
      PROXIMA_RODADA: begin contaL = 1'b1; db_estado = estado; end
      FIM_ACERTOU:    begin acertou = 1'b1; pronto = 1'b1; db_estado = estado; end
      FIM_ERROU:      begin errou = 1'b1; pronto = 1'b1; db_estado = estado; end
`ifdef JOGO_TIMEOUT_EN
      FIM_TIMEOUT:    begin timeout = 1'b1; pronto = 1'b1; db_estado = estado; end
`endif
      default:        db_estado = DB_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_jogo_rodadas_unidade_controle.sv
// Self-checking bench for jogo_rodadas_unidade_controle: directed and randomized games
// checked cycle by cycle against a play-level model of the game rules.
module tb_jogo_rodadas_unidade_controle;

  localparam int TO = 8;
`ifdef JOGO_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, jogada, igual, fimE, fimL;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
  logic acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int checks = 0;
  int failures = 0;
  int contaECount = 0;
  int contaLCount = 0;
  int res;

  always #5 clock = ~clock;

  jogo_rodadas_unidade_controle #(
    .TIMEOUT_CYCLES(TO),
    .TW(4)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimE(fimE), .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  // Bit order: zeraE contaE zeraL contaL zeraR registraR acertou errou timeout pronto
  function automatic logic [9:0] expectedOutputs(input logic [3:0] code);
    logic [9:0] v;
    v = '0;
    case (code)
      4'h0, 4'h1: v = 10'b1010100000;
      4'h2:       v = 10'b1000000000;
      4'h4:       v = 10'b0000010000;
      4'h6:       v = 10'b0100000000;
      4'h7:       v = 10'b0001000000;
      4'hA:       v = 10'b0000001001;
      4'hE:       v = 10'b0000000101;
      4'hD:       v = 10'b0000000011;
      default:    v = 10'b0000000000;
    endcase
    return v;
  endfunction

  task automatic checkOutput(input logic [3:0] code, input string tag);
    logic [9:0] obs;
    obs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};
    checks++;
    assert (db_estado === code) else begin
      failures++;
      $error("[TB] FAIL %s db_estado observed=%h expected=%h", tag, db_estado, code);
    end
    checks++;
    assert (obs === expectedOutputs(code)) else begin
      failures++;
      $error("[TB] FAIL %s outputs observed=%b expected=%b", tag, obs, expectedOutputs(code));
    end
    if (contaE === 1'b1) contaECount++;
    if (contaL === 1'b1) contaLCount++;
  endtask

  task automatic applyStimulus(input logic [3:0] code, input string tag);
    @(posedge clock);
    #1;
    checkOutput(code, tag);
  endtask

  // Presses that the current state must ignore.
  task automatic noise();
    iniciar = 1'($urandom_range(0, 1));
    jogada  = 1'($urandom_range(0, 1));
  endtask

  task automatic startGame();
    iniciar = 1'b1;
    jogada  = 1'($urandom_range(0, 1));
    applyStimulus(4'h1, "preparacao");
    noise();
    applyStimulus(4'h2, "inicio_rodada");
    noise();
    applyStimulus(4'h3, "espera_jogada");
    iniciar = 1'b0;
    jogada  = 1'b0;
  endtask

  // Entered on the first cycle of espera_jogada. res: 0 next play, 1 next round,
  // 2 won, 3 wrong, 4 timed out.
  task automatic playOne(input int delay, input bit ig, input bit fE, input bit fL, output int r);
    r = -1;
    for (int k = 1; k <= delay + 1; k++) begin
      if (k == delay + 1) begin
        jogada = 1'b1;
        applyStimulus(4'h4, "registra");
      end else if (TIMEOUT_ON && k == TO) begin
        applyStimulus(4'hD, "fim_timeout");
        r = 4;
        return;
      end else begin
        applyStimulus(4'h3, "espera_jogada");
      end
    end
    noise();
    igual = ig; fimE = fE; fimL = fL;
    applyStimulus(4'h5, "comparacao");
    noise();
    if (!ig) begin
      applyStimulus(4'hE, "fim_errou"); r = 3;
    end else if (!fE) begin
      applyStimulus(4'h6, "proxima_jogada");
      iniciar = 1'b0; jogada = 1'b0;
      applyStimulus(4'h3, "espera_jogada"); r = 0;
    end else if (!fL) begin
      applyStimulus(4'h7, "proxima_rodada");
      noise();
      applyStimulus(4'h2, "inicio_rodada");
      iniciar = 1'b0; jogada = 1'b0;
      applyStimulus(4'h3, "espera_jogada"); r = 1;
    end else begin
      applyStimulus(4'hA, "fim_acertou"); r = 2;
    end
    iniciar = 1'b0; jogada = 1'b0;
  endtask

  // Round r has r plays; the listed (round, play) positions get a wrong answer or no answer.
  task automatic runGame(input int rounds, input int errRound, input int errPlay,
                         input int toRound, input int toPlay, output int r);
    int delay;
    r = -1;
    startGame();
    for (int rd = 1; rd <= rounds; rd++) begin
      for (int p = 1; p <= rd; p++) begin
        delay = (rd == toRound && p == toPlay) ? TO + 5 : int'($urandom_range(0, TO - 1));
        playOne(delay, !(rd == errRound && p == errPlay), p == rd, rd == rounds, r);
        if (r >= 2) return;
      end
    end
  endtask

  task automatic holdFinal(input logic [3:0] code);
    iniciar = 1'b0;
    repeat (2) begin
      jogada = 1'($urandom_range(0, 1));
      applyStimulus(code, "fim_hold");
    end
    jogada = 1'b0;
  endtask

  initial begin
    int rounds, er, ep, tr, tp;
    logic [3:0] finalCode;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimE = 1'b0; fimL = 1'b0;
    applyStimulus(4'h0, "reset");
    reset = 1'b0;
    applyStimulus(4'h0, "inicial_idle");

    // Reset held for two cycles while in comparacao.
    startGame();
    jogada = 1'b1;
    applyStimulus(4'h4, "registra");
    jogada = 1'b0;
    applyStimulus(4'h5, "comparacao");
    reset = 1'b1;
    applyStimulus(4'h0, "reset_mid_1");
    applyStimulus(4'h0, "reset_mid_2");
    reset = 1'b0;
    applyStimulus(4'h0, "after_reset");

    // One-round win.
    contaECount = 0; contaLCount = 0;
    runGame(1, 0, 0, 0, 0, res);
    holdFinal(4'hA);
    checks++;
    assert (contaECount == 0 && contaLCount == 0) else begin
      failures++;
      $error("[TB] FAIL win1_pulses observed contaE=%0d contaL=%0d expected 0 0", contaECount, contaLCount);
    end

    // Three-round win.
    contaECount = 0; contaLCount = 0;
    runGame(3, 0, 0, 0, 0, res);
    holdFinal(4'hA);
    checks++;
    assert (contaECount == 3 && contaLCount == 2) else begin
      failures++;
      $error("[TB] FAIL win3_pulses observed contaE=%0d contaL=%0d expected 3 2", contaECount, contaLCount);
    end

    // Wrong second play in round 2; restart from fim_errou.
    runGame(3, 2, 2, 0, 0, res);
    holdFinal(4'hE);

    if (TIMEOUT_ON) begin
      runGame(2, 0, 0, 2, 1, res);
      holdFinal(4'hD);
      startGame();
      playOne(TO - 1, 1'b1, 1'b1, 1'b1, res);
      holdFinal(4'hA);
      startGame();
      repeat (5) applyStimulus(4'h3, "espera_pre_reset");
      reset = 1'b1;
      applyStimulus(4'h0, "reset_in_wait");
      reset = 1'b0;
      startGame();
      playOne(TO + 5, 1'b1, 1'b1, 1'b1, res);
      holdFinal(4'hD);
    end else begin
      startGame();
      repeat (100) applyStimulus(4'h3, "espera_sem_timeout");
      playOne(0, 1'b1, 1'b1, 1'b1, res);
      holdFinal(4'hA);
    end

    repeat (15) begin
      rounds = int'($urandom_range(1, 4));
      er = 0; ep = 0; tr = 0; tp = 0;
      if ($urandom_range(0, 2) == 0) begin
        er = int'($urandom_range(1, rounds));
        ep = int'($urandom_range(1, er));
      end
      if (TIMEOUT_ON && $urandom_range(0, 2) == 0) begin
        tr = int'($urandom_range(1, rounds));
        tp = int'($urandom_range(1, tr));
      end
      runGame(rounds, er, ep, tr, tp, res);
      finalCode = (res == 2) ? 4'hA : (res == 3) ? 4'hE : 4'hD;
      holdFinal(finalCode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jogo_rodadas_unidade_controle.md
Name: jogo_rodadas_unidade_controle

Overview:
Moore control unit for the round-based memory game (sequence grows by one play per round).
- Sequences the datapath's play counter (E), round-limit counter (L) and play register (R).
- Includes a per-play response timeout.
- Sits beside the datapath in the top-level game module; all datapath status flags come in as inputs.

Parameters:
TIMEOUT_CYCLES, 5000, clock cycles allowed in espera_jogada before timeout (5 s at 1 kHz); minimum 2
TW, 13, timeout counter width; must satisfy 2^TW >= TIMEOUT_CYCLES

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
iniciar  input  1  start/restart game
jogada  input  1  one-cycle pulse: player pressed a button (already edge-detected)
igual  input  1  registered play equals memory word
fimE  input  1  play counter equals round limit (last play of round)
fimL  input  1  round counter at final round
zeraE  output  1  clear play counter
contaE  output  1  increment play counter
zeraL  output  1  clear round counter
contaL  output  1  increment round counter
zeraR  output  1  clear play register
registraR  output  1  load play register
acertou  output  1  game won
errou  output  1  wrong play
timeout  output  1  player too slow
pronto  output  1  game finished (any outcome)
db_estado  output  4  debug state code

Behaviour:
- Reset: one clock and reset are fixed. Reset is synchronous and active-high: with reset high at a rising edge, state goes to inicial and the timeout counter goes to 0, including mid-game.
- Outputs after reset (state inicial): zeraE=zeraL=zeraR=1, all others 0, db_estado=0.
- All outputs are Moore functions of state only; an input change affects outputs one cycle later.
- States and transitions (db_estado code):
  - inicial (0): iniciar -> preparacao.
  - preparacao (1): -> inicio_rodada. Asserts zeraE, zeraL, zeraR.
  - inicio_rodada (2): -> espera_jogada. Asserts zeraE.
  - espera_jogada (3):
    - jogada -> registra;
    - else if timeout counter == TIMEOUT_CYCLES-1 -> fim_timeout;
    - else stay.
    - jogada wins over a simultaneous timeout.
  - registra (4): -> comparacao. Asserts registraR.
  - comparacao (5):
    - ~igual -> fim_errou;
    - igual & ~fimE -> proxima_jogada;
    - igual & fimE & ~fimL -> proxima_rodada;
    - igual & fimE & fimL -> fim_acertou.
  - proxima_jogada (6): -> espera_jogada. Asserts contaE.
  - proxima_rodada (7): -> inicio_rodada. Asserts contaL.
  - fim_acertou (A): asserts acertou, pronto.
  - fim_errou (E): asserts errou, pronto.
  - fim_timeout (D): asserts timeout, pronto.
  - In all three fim states: iniciar -> preparacao, else stay.
- Timeout counter:
  - Increments each cycle in espera_jogada.
  - Held at 0 in every other state, so it restarts for every play.
  - Never wraps, because the FSM leaves espera_jogada at TIMEOUT_CYCLES-1.
- Unused encodings (8, 9, B, C, F): next state inicial; db_estado=F while in them.
- jogada outside espera_jogada is ignored.
- iniciar outside inicial and fim states is ignored.

Optional Feature:
JOGO_TIMEOUT_EN:
- Defined: timeout counter, fim_timeout state and timeout output behave as above.
- Undefined:
  - no counter logic is generated;
  - espera_jogada waits indefinitely for jogada;
  - timeout is tied to 0;
  - fim_timeout is unreachable and, if entered, falls to inicial like any unused code.

Decomposition:
- Package jogo_pkg: 4-bit state encodings (0-7, A, D, E), DB_INVALIDO=4'hF, default TIMEOUT_CYCLES.
- One sub-module, contador_timeout:
  - parameters TIMEOUT_CYCLES, TW;
  - inputs clock, reset, conta;
  - output fim = (count == TIMEOUT_CYCLES-1);
  - count clears whenever conta=0.

Test Plan (bench uses TIMEOUT_CYCLES=8):
1. reset=1 for 2 cycles mid-game (state 5) -> next cycle db_estado=0, zeraE=zeraL=zeraR=1, pronto=0.
2. Win: iniciar; one round, one play, igual=1, fimE=1, fimL=1 -> path 0,1,2,3,4,5,A; acertou=pronto=1; contaE and contaL never asserted.
3. Three-round win (fimE asserted on plays 1, 2, 3 of rounds 1, 2, 3; fimL in round 3) -> contaL pulses exactly 2 times, contaE pulses 0+1+2=3 times, ends in A.
4. Wrong play in round 2 (igual=0) -> comparacao goes to E; errou=pronto=1; then iniciar -> state 1 with zeraL=1.
5. No jogada in espera_jogada -> after exactly 8 cycles in state 3, state D, timeout=pronto=1. jogada pulsed on the 8th cycle instead -> state 4, no timeout.
6. JOGO_TIMEOUT_EN undefined -> 100 idle cycles stay in state 3 with timeout=0.
